// File: rtl/sync_fifo_stream.sv
// Elastic stream buffer: RAM plus a registered first-word-fall-through head,
// with programmable almost-full/empty flags and a peak-occupancy watermark.
module sync_fifo_stream #(
  parameter int DATA_WIDTH = 8,
  parameter int DEPTH      = 32,
  parameter int CW         = $clog2(DEPTH+1)
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  clear,
  input  logic                  s_valid,
  output logic                  s_ready,
  input  logic [DATA_WIDTH-1:0] s_data,
  output logic                  m_valid,
  input  logic                  m_ready,
  output logic [DATA_WIDTH-1:0] m_data,
  input  logic [CW-1:0]         afull_thr,
  input  logic [CW-1:0]         aempty_thr,
  output logic [CW-1:0]         count,
  output logic                  afull,
  output logic                  aempty,
  output logic [CW-1:0]         max_count
);

  localparam int RD = DEPTH - 1;
  localparam int PW = (RD > 1) ? $clog2(RD) : 1;
  localparam logic [PW-1:0] LAST = PW'(RD - 1);
  localparam logic [CW-1:0] FULL = CW'(DEPTH);

  logic [DATA_WIDTH-1:0] mem_q [RD];

  logic [PW-1:0]         wptr_q, wptr_d;
  logic [PW-1:0]         rptr_q, rptr_d;
  logic [CW-1:0]         count_q, count_d;
  logic [CW-1:0]         max_q, max_d;
  logic                  rdy_q, rdy_d;
  logic                  ov_q, ov_d;
  logic [DATA_WIDTH-1:0] od_q, od_d;

  logic push, pop, ram_empty, or_free;
  logic ld_ram, bypass, ram_wr;

  function automatic logic [PW-1:0] inc(input logic [PW-1:0] p);
    return (p == LAST) ? '0 : p + 1'b1;
  endfunction

  assign push      = s_valid && rdy_q;
  assign pop       = ov_q && m_ready;
  // RAM is empty when every counted entry sits in the head register
  assign ram_empty = (count_q == CW'(ov_q));
  assign or_free   = !ov_q || pop;
  assign ld_ram    = or_free && !ram_empty;
  assign bypass    = or_free && ram_empty && push;
  assign ram_wr    = push && !bypass;

  always_comb begin
    wptr_d  = wptr_q;
    rptr_d  = rptr_q;
    ov_d    = ov_q;
    od_d    = od_q;
    count_d = count_q;
    if (push && !pop)      count_d = count_q + 1'b1;
    else if (pop && !push) count_d = count_q - 1'b1;
    if (ld_ram) begin
      ov_d   = 1'b1;
      od_d   = mem_q[rptr_q];
      rptr_d = inc(rptr_q);
    end else if (bypass) begin
      ov_d = 1'b1;
      od_d = s_data;
    end else if (pop) begin
      ov_d = 1'b0;
    end
    if (ram_wr) wptr_d = inc(wptr_q);
    max_d = (count_d > max_q) ? count_d : max_q;
    rdy_d = (count_d < FULL);
    if (clear) begin
      wptr_d  = '0;
      rptr_d  = '0;
      ov_d    = 1'b0;
      count_d = '0;
      max_d   = '0;
      rdy_d   = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wptr_q  <= '0;
      rptr_q  <= '0;
      ov_q    <= 1'b0;
      od_q    <= '0;
      count_q <= '0;
      max_q   <= '0;
      rdy_q   <= 1'b0;
    end else begin
      wptr_q  <= wptr_d;
      rptr_q  <= rptr_d;
      ov_q    <= ov_d;
      od_q    <= od_d;
      count_q <= count_d;
      max_q   <= max_d;
      rdy_q   <= rdy_d;
    end
  end

  always_ff @(posedge clk) begin
    if (ram_wr && !clear) mem_q[wptr_q] <= s_data;
  end

  assign s_ready   = rdy_q;
  assign m_valid   = ov_q;
  assign m_data    = od_q;
  assign count     = count_q;
  assign max_count = max_q;
  assign afull     = (count_q >= afull_thr);
  assign aempty    = (count_q <= aempty_thr);

endmodule

// File: tb/tb_sync_fifo_stream.sv
// Bench for sync_fifo_stream at DEPTH=4: scoreboard queue checks every
// accepted beat comes out once and in order; tasks check flags and state.
module tb_sync_fifo_stream;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       clear;
  logic       s_valid;
  logic       s_ready;
  logic [7:0] s_data;
  logic       m_valid;
  logic       m_ready;
  logic [7:0] m_data;
  logic [2:0] afull_thr;
  logic [2:0] aempty_thr;
  logic [2:0] count;
  logic       afull;
  logic       aempty;
  logic [2:0] max_count;

  int n_checks = 0;
  int n_fail   = 0;
  int n_pops   = 0;
  logic [7:0] sb[$];

  sync_fifo_stream #(.DATA_WIDTH(8), .DEPTH(4)) dut (
    .clk(clk), .rst_n(rst_n), .clear(clear),
    .s_valid(s_valid), .s_ready(s_ready), .s_data(s_data),
    .m_valid(m_valid), .m_ready(m_ready), .m_data(m_data),
    .afull_thr(afull_thr), .aempty_thr(aempty_thr),
    .count(count), .afull(afull), .aempty(aempty),
    .max_count(max_count)
  );

  always #5 clk = ~clk;

  // Scoreboard: sampled mid-cycle, reflects the handshakes of the next edge
  always @(negedge clk) begin
    if (!rst_n || clear) begin
      sb.delete();
    end else begin
      if (m_valid && m_ready) begin
        n_checks++;
        n_pops++;
        if (sb.size() == 0) begin
          n_fail++;
          $display("FAIL sb_pop: got %h, required no beat (queue empty)", m_data);
        end else begin
          logic [7:0] e;
          e = sb.pop_front();
          if (m_data !== e) begin
            n_fail++;
            $display("FAIL sb_order: got %h, required %h", m_data, e);
          end
        end
      end
      if (s_valid && s_ready) sb.push_back(s_data);
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; clear = 1'b0; s_valid = 1'b0; s_data = 8'h00;
    m_ready = 1'b0; afull_thr = 3'd3; aempty_thr = 3'd1;
    tick(); tick();
    n_checks += 7;
    if (m_valid !== 1'b0) begin n_fail++; $display("FAIL rst_mvalid: got %b, required 0", m_valid); end
    if (m_data !== 8'h00) begin n_fail++; $display("FAIL rst_mdata: got %h, required 00", m_data); end
    if (s_ready !== 1'b0) begin n_fail++; $display("FAIL rst_sready: got %b, required 0", s_ready); end
    if (count !== 3'd0) begin n_fail++; $display("FAIL rst_count: got %0d, required 0", count); end
    if (max_count !== 3'd0) begin n_fail++; $display("FAIL rst_max: got %0d, required 0", max_count); end
    if (aempty !== 1'b1) begin n_fail++; $display("FAIL rst_aempty: got %b, required 1", aempty); end
    if (afull !== 1'b0) begin n_fail++; $display("FAIL rst_afull: got %b, required 0", afull); end
    rst_n = 1'b1;
    tick();
    n_checks++;
    if (s_ready !== 1'b1) begin n_fail++; $display("FAIL rel_sready: got %b, required 1", s_ready); end
    s_valid = 1'b1; s_data = 8'hA1;
    tick();
    s_valid = 1'b0;
    n_checks += 3;
    if (m_valid !== 1'b1) begin n_fail++; $display("FAIL first_mvalid: got %b, required 1", m_valid); end
    if (m_data !== 8'hA1) begin n_fail++; $display("FAIL first_mdata: got %h, required a1", m_data); end
    if (count !== 3'd1) begin n_fail++; $display("FAIL first_count: got %0d, required 1", count); end
    m_ready = 1'b1;
    tick();
    m_ready = 1'b0;
    n_checks++;
    if (count !== 3'd0) begin n_fail++; $display("FAIL first_drain: got %0d, required 0", count); end
  endtask

  task automatic test_fill();
    int i = 1;
    int acc = 0;
    for (int c = 0; c < 8; c++) begin
      logic go;
      s_valid = 1'b1;
      s_data  = 8'(i);
      go = s_ready;
      tick();
      if (go && i < 5) begin acc++; i++; end
    end
    n_checks += 6;
    if (acc !== 4) begin n_fail++; $display("FAIL fill_accepted: got %0d, required 4", acc); end
    if (count !== 3'd4) begin n_fail++; $display("FAIL fill_count: got %0d, required 4", count); end
    if (s_ready !== 1'b0) begin n_fail++; $display("FAIL fill_sready: got %b, required 0", s_ready); end
    if (max_count !== 3'd4) begin n_fail++; $display("FAIL fill_max: got %0d, required 4", max_count); end
    if (m_data !== 8'h01) begin n_fail++; $display("FAIL fill_head: got %h, required 01", m_data); end
    if (s_data !== 8'h05) begin n_fail++; $display("FAIL fill_held: got %h, required 05", s_data); end
  endtask

  task automatic test_drain_full();
    int p0 = n_pops;
    m_ready = 1'b1;
    for (int c = 0; c < 6; c++) begin
      logic acc;
      acc = s_valid && s_ready;
      tick();
      if (acc) s_valid = 1'b0;
      if (c == 0) begin
        n_checks++;
        if (s_ready !== 1'b1) begin n_fail++; $display("FAIL drain_sready: got %b, required 1", s_ready); end
      end
    end
    m_ready = 1'b0;
    s_valid = 1'b0;
    n_checks += 3;
    if (n_pops - p0 !== 5) begin n_fail++; $display("FAIL drain_pops: got %0d, required 5", n_pops - p0); end
    if (count !== 3'd0) begin n_fail++; $display("FAIL drain_count: got %0d, required 0", count); end
    if (sb.size() !== 0) begin n_fail++; $display("FAIL drain_left: got %0d, required 0", sb.size()); end
  endtask

  task automatic test_stream();
    int p0;
    clear = 1'b1;
    tick();
    clear = 1'b0;
    n_checks++;
    if (max_count !== 3'd0) begin n_fail++; $display("FAIL clr_max: got %0d, required 0", max_count); end
    p0 = n_pops;
    m_ready = 1'b1;
    s_valid = 1'b1;
    for (int c = 0; c < 8; c++) begin
      s_data = 8'h10 + 8'(c);
      tick();
      n_checks++;
      if (count !== 3'd1) begin n_fail++; $display("FAIL stream_count: got %0d, required 1", count); end
    end
    s_valid = 1'b0;
    tick();
    m_ready = 1'b0;
    n_checks += 3;
    if (max_count !== 3'd1) begin n_fail++; $display("FAIL stream_max: got %0d, required 1", max_count); end
    if (count !== 3'd0) begin n_fail++; $display("FAIL stream_end: got %0d, required 0", count); end
    if (n_pops - p0 !== 8) begin n_fail++; $display("FAIL stream_pops: got %0d, required 8", n_pops - p0); end
  endtask

  task automatic test_thresholds();
    logic ae_t[5] = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b0};
    logic af_t[5] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b1};
    afull_thr = 3'd3; aempty_thr = 3'd1; m_ready = 1'b0;
    for (int k = 0; k < 5; k++) begin
      n_checks += 2;
      if (aempty !== ae_t[k]) begin n_fail++; $display("FAIL aempty_occ%0d: got %b, required %b", k, aempty, ae_t[k]); end
      if (afull !== af_t[k]) begin n_fail++; $display("FAIL afull_occ%0d: got %b, required %b", k, afull, af_t[k]); end
      if (k < 4) begin
        s_valid = 1'b1; s_data = 8'h20 + 8'(k);
        tick();
        s_valid = 1'b0;
      end
    end
    aempty_thr = 3'd4; afull_thr = 3'd0;
    #1;
    n_checks += 2;
    if (aempty !== 1'b1) begin n_fail++; $display("FAIL aempty_max_thr: got %b, required 1", aempty); end
    if (afull !== 1'b1) begin n_fail++; $display("FAIL afull_zero_thr: got %b, required 1", afull); end
    afull_thr = 3'd3; aempty_thr = 3'd1;
    m_ready = 1'b1;
    tick();
    m_ready = 1'b0;
    n_checks++;
    if (count !== 3'd3) begin n_fail++; $display("FAIL thr_pop: got %0d, required 3", count); end
  endtask

  task automatic test_clear();
    clear = 1'b1; s_valid = 1'b1; s_data = 8'hEE; m_ready = 1'b1;
    tick();
    clear = 1'b0; s_valid = 1'b0;
    n_checks += 4;
    if (count !== 3'd0) begin n_fail++; $display("FAIL clr_count: got %0d, required 0", count); end
    if (m_valid !== 1'b0) begin n_fail++; $display("FAIL clr_mvalid: got %b, required 0", m_valid); end
    if (max_count !== 3'd0) begin n_fail++; $display("FAIL clr_peak: got %0d, required 0", max_count); end
    if (s_ready !== 1'b1) begin n_fail++; $display("FAIL clr_sready: got %b, required 1", s_ready); end
    for (int c = 0; c < 3; c++) begin
      tick();
      n_checks++;
      if (m_valid !== 1'b0) begin n_fail++; $display("FAIL clr_ghost: got %b %h, required 0", m_valid, m_data); end
    end
    m_ready = 1'b0;
  endtask

  task automatic test_reset_mid();
    for (int k = 0; k < 3; k++) begin
      s_valid = 1'b1; s_data = 8'h30 + 8'(k);
      tick();
    end
    #2;
    rst_n = 1'b0;
    #1;
    n_checks += 4;
    if (count !== 3'd0) begin n_fail++; $display("FAIL mrst_count: got %0d, required 0", count); end
    if (m_valid !== 1'b0) begin n_fail++; $display("FAIL mrst_mvalid: got %b, required 0", m_valid); end
    if (s_ready !== 1'b0) begin n_fail++; $display("FAIL mrst_sready: got %b, required 0", s_ready); end
    if (max_count !== 3'd0) begin n_fail++; $display("FAIL mrst_max: got %0d, required 0", max_count); end
    tick();
    rst_n = 1'b1;
    #1;
    n_checks++;
    if (s_ready !== 1'b0) begin n_fail++; $display("FAIL mrst_early: got %b, required 0", s_ready); end
    s_valid = 1'b0;
    m_ready = 1'b1;
    tick();
    n_checks += 2;
    if (s_ready !== 1'b1) begin n_fail++; $display("FAIL mrst_rel: got %b, required 1", s_ready); end
    if (m_valid !== 1'b0) begin n_fail++; $display("FAIL mrst_empty: got %b, required 0", m_valid); end
    tick(); tick();
    m_ready = 1'b0;
    n_checks++;
    if (count !== 3'd0) begin n_fail++; $display("FAIL mrst_final: got %0d, required 0", count); end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, required finish");
    $fatal(1, "timeout");
  end

  initial begin
    test_reset();
    test_fill();
    test_drain_full();
    test_stream();
    test_thresholds();
    test_clear();
    test_reset_mid();
    tick();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/sync_fifo_stream.md
Name: sync_fifo_stream

Overview:
- Parametrised synchronous FIFO with valid/ready streaming ports on both sides and a first-word-fall-through registered output stage.
- Adds runtime-programmable almost-full/almost-empty thresholds, a peak-occupancy watermark and synchronous clear.
- Used as the standard elastic buffer between streaming pipeline stages in a single clock domain.

Parameters:
- DATA_WIDTH, 8, width of the data word.
- DEPTH, 32, total capacity in entries, including the output register. Must be >= 2; any integer value is allowed.
- CW, $clog2(DEPTH+1), width of the count and threshold fields.

Ports:
- clk  in  1  clock.
- rst_n  in  1  asynchronous, active-low reset.
- clear  in  1  synchronous flush.
- s_valid  in  1  write beat valid.
- s_ready  out  1  FIFO can accept a write beat.
- s_data  in  DATA_WIDTH  write data.
- m_valid  out  1  read beat valid.
- m_ready  in  1  consumer accepts the read beat.
- m_data  out  DATA_WIDTH  read data; registered output.
- afull_thr  in  CW  almost-full threshold.
- aempty_thr  in  CW  almost-empty threshold.
- count  out  CW  current occupancy.
- afull  out  1  count >= afull_thr.
- aempty  out  1  count <= aempty_thr.
- max_count  out  CW  peak occupancy since reset or clear.

Behaviour:
- Storage: DEPTH-1 entry RAM plus one output register (OR). Read/write pointers wrap from DEPTH-2 to 0. count covers RAM plus OR.
- Push = s_valid && s_ready. Pop = m_valid && m_ready.
- s_ready is registered: s_ready <= (count_next < DEPTH).
  - No combinational path exists from m_ready to s_ready.
  - When full, a same-cycle pop does not allow a push. s_ready rises the cycle after the pop.
- OR load, evaluated each cycle:
  - If OR is empty or popping and RAM is non-empty: OR <= RAM head, rptr++.
  - Else if OR is empty or popping, RAM is empty and push: OR <= s_data (bypass; RAM is not written).
  - Else, on push: RAM[wptr] <= s_data, wptr++.
- Latency: a push into an empty FIFO at edge N gives m_valid=1 with that data immediately after edge N (1 cycle).
- m_valid and m_data hold stable while m_valid && !m_ready.
- count_next: +1 on push only, -1 on pop only, unchanged on both or neither.
- Ordering is strict FIFO across RAM and bypass paths, including simultaneous push/pop at every occupancy.
- afull and aempty are combinational from registered count, compared unsigned.
  - afull_thr = 0 gives afull always 1.
  - aempty_thr >= DEPTH gives aempty always 1.
- max_count <= max(max_count, count_next) every cycle.
- clear has highest priority and is synchronous. Next cycle: count=0, pointers=0, m_valid=0, s_ready=1, max_count=0. A push or pop in the clear cycle is discarded.
- Reset: m_valid=0, m_data=0, s_ready=0, count=0, max_count=0, pointers=0.
  - afull and aempty follow count.
  - s_ready rises on the first clk edge after rst_n deasserts.
  - Reset mid-operation discards all contents.

Test Plan:
- DEPTH=4, reset release, push 0xA1 in the 2nd cycle with m_ready=0 -> s_ready=1 from cycle 1; m_valid=1, m_data=0xA1, count=1 after the push edge.
- DEPTH=4, push 0x01..0x05 back-to-back with m_ready=0 -> 4 beats accepted; s_ready=0 after count=4; max_count=4; 0x05 held on s_data.
- DEPTH=4 full, m_ready=1 and s_valid=1 for 6 cycles -> output order 0x01,0x02,0x03,0x04,0x05; s_ready returns 1 one cycle after the first pop; no loss or duplication.
- DEPTH=4, continuous push and pop at 1 beat/cycle from empty -> count stays at 1; data order preserved through the bypass path; max_count=1.
- afull_thr=3, aempty_thr=1: occupancy 0,1,2,3,4 -> aempty 1,1,0,0,0; afull 0,0,0,1,1.
- DEPTH=4 with count=3, assert clear together with s_valid and m_ready -> next cycle count=0, m_valid=0, max_count=0, s_ready=1; the discarded beat never appears. Repeat with rst_n pulsed mid-stream -> same empty state, with s_ready=0 until the first edge after release.
